bram_verified_mem: RTL and testbench

- Parametrised single-port data memory for the miniRISC data path; replaces the fixed 8K x 32 data-memory wrapper.
- Adds byte-lane writes, configurable read latency, a req/ready handshake and a tagged rvalid.
- Adds an optional hardware write-verify engine: it reads back every write, compares the enabled lanes, and logs errors.
- Sits between the MEM stage and the block RAM; the verify counters are visible to debug logic.

---
 rtl/bram_verified_mem.sv | 184 ++++++++++++++++++
 tb/tb_bram_verified_mem.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_verified_mem.sv
// bram_verified_mem
//   Single-port data memory for the miniRISC data path. It supports byte-lane
//   writes and a read latency of 1 or 2 cycles, with a req/ready handshake and
//   a tagged read pipeline. When VERIFY_EN is set, an engine reads back every
//   write, compares the enabled lanes and keeps an error log.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (memory array is not cleared)
//   req/we     request valid / 1 = write, 0 = read (accepted when req && ready)
//   be         byte-lane write enables, lane i = bits 8i+7:8i
//   addr       word address
//   din        write data
//   fault_inj  test hook: stores din[0] inverted on a write with be[0]=1
//   clr_err    synchronous clear of the error log
//   ready      request can be accepted this cycle
//   rvalid     one-cycle pulse, rdata carries host read data
//   rdata      read data, held between rvalid pulses
//   vdone      one-cycle pulse, a verify has completed
//   verr       one-cycle pulse with vdone, verify mismatch
//   err_cnt    saturating mismatch count
//   err_addr   address of the first mismatch since the last clear
module bram_verified_mem #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int READ_LAT  = 1,
  parameter int VERIFY_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic                  fault_inj,
  input  logic                  clr_err,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  vdone,
  output logic                  verr,
  output logic [15:0]           err_cnt,
  output logic [ADDR_W-1:0]     err_addr
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, VRD, VWAIT, VCMP} state_t;

  function automatic logic lanes_differ(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [NB-1:0]     m);
    logic d;
    d = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (m[i] && (a[8*i +: 8] != b[8*i +: 8])) d = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state;
  logic              acc_rd, acc_wr, vrd_issue, rd_issue;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wdata;

  logic              vld_p0, host_p0, vld_p1, host_p1;
  logic [DATA_W-1:0] rd_p0, rd_p1;
  logic              vld_last, host_last;
  logic [DATA_W-1:0] data_last;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] v_addr;
  logic [NB-1:0]     v_be;
  logic [DATA_W-1:0] v_exp;
  logic              v_mis;
  logic              err_seen;
  logic              vexit;

  // While the engine is busy the port belongs to it; VCMP already behaves as IDLE.
  assign ready     = (VERIFY_EN == 0) || (state == IDLE) || (state == VCMP);
  assign acc_rd    = req && ready && !we;
  assign acc_wr    = req && ready && we;
  assign vrd_issue = (state == VRD);
  assign rd_issue  = acc_rd || vrd_issue;
  assign rd_addr   = vrd_issue ? v_addr : addr;

  // The fault hook only flips what is stored; the expected word keeps din.
  assign wdata = {din[DATA_W-1:1], din[0] ^ (fault_inj & be[0])};

  // Stage p0: array access (byte-lane write or registered read)
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_issue) rd_p0 <= mem[rd_addr];
  end

  // Stage p1: optional output register for READ_LAT=2
  always_ff @(posedge clk) begin
    if (vld_p0) rd_p1 <= rd_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      host_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      host_p1 <= 1'b0;
    end else begin
      vld_p0  <= rd_issue;
      host_p0 <= acc_rd;
      vld_p1  <= vld_p0;
      host_p1 <= host_p0;
    end
  end

  assign vld_last  = (READ_LAT == 2) ? vld_p1  : vld_p0;
  assign host_last = (READ_LAT == 2) ? host_p1 : host_p0;
  assign data_last = (READ_LAT == 2) ? rd_p1   : rd_p0;
  assign vexit     = vld_last && !host_last;

  // Pipeline exit: host entries go to rdata, verify entries only to the comparator
  assign rvalid = vld_last && host_last;
  assign rdata  = rvalid ? data_last : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (rvalid) rdata_q <= data_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, VCMP: state <= (acc_wr && (VERIFY_EN != 0)) ? VRD : IDLE;
        VRD:        state <= VWAIT;
        VWAIT:      if (vexit) state <= VCMP;
        default:    state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      v_addr <= addr;
      v_be   <= be;
      v_exp  <= din;
    end
    if ((state == VWAIT) && vexit) v_mis <= lanes_differ(data_last, v_exp, v_be);
  end

  assign vdone = (state == VCMP);
  assign verr  = vdone && v_mis;

  // Error log: clr_err restarts the log, and a coincident mismatch becomes its first entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= 16'd0;
      err_addr <= '0;
      err_seen <= 1'b0;
    end else if (clr_err) begin
      err_cnt  <= {15'd0, verr};
      err_addr <= verr ? v_addr : '0;
      err_seen <= verr;
    end else if (verr) begin
      err_cnt <= sat_inc16(err_cnt);
      if (!err_seen) begin
        err_addr <= v_addr;
        err_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_verified_mem.sv
module tb_bram_verified_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: READ_LAT=1, index 1: READ_LAT=2
  logic        rst_n[2], req[2], we[2], fault_inj[2], clr_err[2];
  logic [3:0]  be[2];
  logic [7:0]  addr[2];
  logic [31:0] din[2];
  logic        ready[2], rvalid[2], vdone[2], verr[2];
  logic [31:0] rdata[2];
  logic [15:0] err_cnt[2];
  logic [7:0]  err_addr[2];

  int errors = 0;
  int checks = 0;

  // reference model: memory image and error log per instance
  logic [31:0] mdl [2][256];
  int          m_cnt[2];
  logic [7:0]  m_eaddr[2];
  bit          m_seen[2];
  bit          m_mis[2];

  bram_verified_mem #(.DATA_W(32), .ADDR_W(8), .READ_LAT(1), .VERIFY_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
    .din(din[0]), .fault_inj(fault_inj[0]), .clr_err(clr_err[0]), .ready(ready[0]),
    .rvalid(rvalid[0]), .rdata(rdata[0]), .vdone(vdone[0]), .verr(verr[0]),
    .err_cnt(err_cnt[0]), .err_addr(err_addr[0]));

  bram_verified_mem #(.DATA_W(32), .ADDR_W(8), .READ_LAT(2), .VERIFY_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
    .din(din[1]), .fault_inj(fault_inj[1]), .clr_err(clr_err[1]), .ready(ready[1]),
    .rvalid(rvalid[1]), .rdata(rdata[1]), .vdone(vdone[1]), .verr(verr[1]),
    .err_cnt(err_cnt[1]), .err_addr(err_addr[1]));

  function automatic int lat_of(input int d);
    return d + 1;
  endfunction

  // Issues one write and watches 8 cycles after acceptance; updates the model.
  task automatic write_op(input int d, input logic [7:0] a, input logic [31:0] data,
                          input logic [3:0] b, input bit fi, input bit clr, input bit rst_mid,
                          output int vd, output bit vr, output int rlow);
    logic [31:0] stored, mask;
    int g;
    vd = 0; vr = 0; rlow = 0; g = 0;
    @(negedge clk);
    while (!ready[d] && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) begin
      errors++; checks++;
      $display("FAIL write_ready_timeout d=%0d got ready=%b want 1", d, ready[d]);
    end
    req[d] = 1'b1; we[d] = 1'b1; addr[d] = a; din[d] = data; be[d] = b; fault_inj[d] = fi;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin req[d] = 1'b0; we[d] = 1'b0; fault_inj[d] = 1'b0; end
      if (!ready[d]) rlow++;
      if (vdone[d] && vd == 0) begin vd = k; vr = verr[d]; end
      clr_err[d] = clr && (k == lat_of(d) + 2);
      if (rst_mid) rst_n[d] = (k != 2);
    end
    stored = data;
    if (fi && b[0]) stored[0] = ~stored[0];
    mask = '0;
    for (int i = 0; i < 4; i++) if (b[i]) mask[8*i +: 8] = 8'hFF;
    mdl[d][a] = (mdl[d][a] & ~mask) | (stored & mask);
    m_mis[d] = (((mdl[d][a] ^ data) & mask) != 0);
    if (rst_mid) begin
      m_cnt[d] = 0; m_eaddr[d] = '0; m_seen[d] = 0; m_mis[d] = 0;
    end else if (clr) begin
      m_cnt[d] = m_mis[d] ? 1 : 0; m_eaddr[d] = m_mis[d] ? a : 8'h00; m_seen[d] = m_mis[d];
    end else if (m_mis[d]) begin
      if (m_cnt[d] < 65535) m_cnt[d]++;
      if (!m_seen[d]) begin m_eaddr[d] = a; m_seen[d] = 1; end
    end
  endtask

  // Issues one read; reports latency of the first rvalid and rdata held at the end.
  task automatic read_op(input int d, input logic [7:0] a, output int lat, output logic [31:0] data,
                         output int rlow, output bit vd, output logic [31:0] hold);
    lat = 0; data = '0; rlow = 0; vd = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req[d] = 1'b0;
      if (!ready[d]) rlow++;
      if (vdone[d]) vd = 1;
      if (rvalid[d] && lat == 0) begin lat = k; data = rdata[d]; end
    end
    hold = rdata[d];
  endtask

  task automatic preload();
    int vd, rl; bit vr;
    for (int a = 0; a < 'h48; a++) begin
      for (int d = 0; d < 2; d++) begin
        write_op(d, 8'(a), (a < 16) ? $urandom : 32'h0, 4'hF, 0, 0, 0, vd, vr, rl);
      end
    end
  endtask

  task automatic test_reset();
    int lat, rl; bit vd; logic [31:0] dt, hd;
    @(negedge clk);
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ready[d], rvalid[d], vdone[d], verr[d], rdata[d], err_cnt[d], err_addr[d]} !== {1'b1, 3'b000, 32'h0, 16'h0, 8'h0}) begin
        errors++;
        $display("FAIL reset_outputs d=%0d got rdy=%b rv=%b vd=%b ve=%b rd=%h cnt=%h ea=%h want rdy=1 others 0",
                 d, ready[d], rvalid[d], vdone[d], verr[d], rdata[d], err_cnt[d], err_addr[d]);
      end
      m_cnt[d] = 0; m_eaddr[d] = '0; m_seen[d] = 0;
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    read_op(0, 8'h05, lat, dt, rl, vd, hd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL reset_read_lat got %0d want 1", lat); end
    checks++; if (dt !== mdl[0][5]) begin errors++; $display("FAIL reset_read_data got %h want %h", dt, mdl[0][5]); end
    checks++; if (rl !== 0 || vd !== 0) begin errors++; $display("FAIL reset_read_ready_vdone got rlow=%0d vdone=%b want 0 0", rl, vd); end
    checks++; if (hd !== mdl[0][5]) begin errors++; $display("FAIL reset_rdata_hold got %h want %h", hd, mdl[0][5]); end
  endtask

  task automatic test_write_verify();
    int vd, rl, lat, rrl; bit vr, rvd; logic [31:0] dt, hd;
    for (int d = 0; d < 2; d++) begin
      write_op(d, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, vd, vr, rl);
      checks++; if (rl !== lat_of(d) + 1) begin errors++; $display("FAIL wv_ready_low d=%0d got %0d want %0d", d, rl, lat_of(d) + 1); end
      checks++; if (vd !== lat_of(d) + 2) begin errors++; $display("FAIL wv_vdone_cycle d=%0d got %0d want %0d", d, vd, lat_of(d) + 2); end
      checks++; if (vr !== 1'b0) begin errors++; $display("FAIL wv_verr d=%0d got %b want 0", d, vr); end
      read_op(d, 8'h10, lat, dt, rrl, rvd, hd);
      checks++; if (dt !== 32'hDEADBEEF || lat !== lat_of(d)) begin errors++; $display("FAIL wv_readback d=%0d got %h lat %0d want deadbeef lat %0d", d, dt, lat, lat_of(d)); end
      checks++; if (err_cnt[d] !== 16'd0) begin errors++; $display("FAIL wv_err_cnt d=%0d got %0d want 0", d, err_cnt[d]); end
    end
  endtask

  task automatic test_byte_lanes();
    int vd, rl, lat, rrl; bit vr, rvd; logic [31:0] dt, hd;
    bit v1, v2;
    write_op(0, 8'h20, 32'h11223344, 4'hF, 0, 0, 0, vd, v1, rl);
    write_op(0, 8'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 0, vd, v2, rl);
    checks++; if ({v1, v2} !== 2'b00) begin errors++; $display("FAIL lanes_verr got %b%b want 00", v1, v2); end
    read_op(0, 8'h20, lat, dt, rrl, rvd, hd);
    checks++; if (dt !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_merge got %h want 11bb33dd", dt); end
    write_op(0, 8'h20, $urandom, 4'h0, 0, 0, 0, vd, vr, rl);
    checks++; if (vd !== 3 || vr !== 1'b0) begin errors++; $display("FAIL be0_verify got vdone@%0d verr=%b want vdone@3 verr=0", vd, vr); end
    read_op(0, 8'h20, lat, dt, rrl, rvd, hd);
    checks++; if (dt !== 32'h11BB33DD) begin errors++; $display("FAIL be0_noop got %h want 11bb33dd", dt); end
  endtask

  task automatic test_fault();
    int vd, rl, lat, rrl; bit vr, rvd; logic [31:0] dt, hd;
    write_op(0, 8'h30, 32'h0, 4'h1, 1, 0, 0, vd, vr, rl);
    checks++; if (vr !== 1'b1 || vd !== 3) begin errors++; $display("FAIL fault_verr got verr=%b vdone@%0d want verr=1 vdone@3", vr, vd); end
    checks++; if (err_cnt[0] !== 16'd1 || err_addr[0] !== 8'h30) begin errors++; $display("FAIL fault_log1 got cnt=%0d addr=%h want 1 30", err_cnt[0], err_addr[0]); end
    read_op(0, 8'h30, lat, dt, rrl, rvd, hd);
    checks++; if (dt !== 32'h00000001) begin errors++; $display("FAIL fault_stored got %h want 00000001", dt); end
    write_op(0, 8'h40, 32'h0, 4'h1, 1, 0, 0, vd, vr, rl);
    checks++; if (err_cnt[0] !== 16'd2 || err_addr[0] !== 8'h30) begin errors++; $display("FAIL fault_log2 got cnt=%0d addr=%h want 2 30", err_cnt[0], err_addr[0]); end
  endtask

  task automatic test_back_to_back();
    int nrv, vdc, rl, lat;
    logic [31:0] rv_data[2];
    int rv_cyc[2];
    logic [31:0] wd;
    for (int d = 0; d < 2; d++) begin
      nrv = 0; vdc = 0; rl = 0; wd = $urandom; lat = lat_of(d);
      rv_cyc[0] = 0; rv_cyc[1] = 0; rv_data[0] = '0; rv_data[1] = '0;
      @(negedge clk);
      req[d] = 1'b1; we[d] = 1'b0; addr[d] = 8'h01;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (rvalid[d]) begin
          if (nrv < 2) begin rv_data[nrv] = rdata[d]; rv_cyc[nrv] = c; end
          nrv++;
        end
        if (vdone[d] && vdc == 0) vdc = c;
        if (!ready[d]) rl++;
        req[d] = (c == 1) || (c == 2);
        we[d] = (c == 2);
        addr[d] = (c == 1) ? 8'h02 : 8'h03;
        din[d] = wd; be[d] = 4'hF;
      end
      checks++; if (nrv !== 2) begin errors++; $display("FAIL b2b_rvalid_count d=%0d got %0d want 2", d, nrv); end
      checks++; if (rv_cyc[0] !== lat || rv_cyc[1] !== lat + 1) begin errors++; $display("FAIL b2b_rvalid_cycles d=%0d got %0d,%0d want %0d,%0d", d, rv_cyc[0], rv_cyc[1], lat, lat + 1); end
      checks++; if (rv_data[0] !== mdl[d][1] || rv_data[1] !== mdl[d][2]) begin errors++; $display("FAIL b2b_rdata d=%0d got %h,%h want %h,%h", d, rv_data[0], rv_data[1], mdl[d][1], mdl[d][2]); end
      checks++; if (vdc !== 2 + lat + 2) begin errors++; $display("FAIL b2b_vdone d=%0d got %0d want %0d", d, vdc, 2 + lat + 2); end
      checks++; if (rl !== lat + 1) begin errors++; $display("FAIL b2b_ready_low d=%0d got %0d want %0d", d, rl, lat + 1); end
      mdl[d][3] = wd;
    end
  endtask

  task automatic test_reset_vwait();
    int vd, rl, lat, rrl; bit vr, rvd; logic [31:0] dt, hd;
    for (int d = 0; d < 2; d++) begin
      write_op(d, 8'h0A, $urandom, 4'hF, 0, 0, 1, vd, vr, rl);
      checks++; if (vd !== 0) begin errors++; $display("FAIL rst_vwait_vdone d=%0d got vdone@%0d want none", d, vd); end
      checks++; if (ready[d] !== 1'b1 || err_cnt[d] !== 16'd0) begin errors++; $display("FAIL rst_vwait_state d=%0d got ready=%b cnt=%0d want 1 0", d, ready[d], err_cnt[d]); end
      read_op(d, 8'h0A, lat, dt, rrl, rvd, hd);
      checks++; if (dt !== mdl[d][8'h0A]) begin errors++; $display("FAIL rst_vwait_mem d=%0d got %h want %h", d, dt, mdl[d][8'h0A]); end
    end
  endtask

  task automatic test_clr_err();
    int vd, rl; bit vr;
    write_op(0, 8'h41, 32'h0, 4'h1, 1, 0, 0, vd, vr, rl);
    write_op(0, 8'h42, 32'h0, 4'h1, 1, 1, 0, vd, vr, rl);
    checks++; if (vr !== 1'b1 || err_cnt[0] !== 16'd1 || err_addr[0] !== 8'h42) begin errors++; $display("FAIL clr_with_verr got verr=%b cnt=%0d addr=%h want 1 1 42", vr, err_cnt[0], err_addr[0]); end
    @(negedge clk); clr_err[0] = 1'b1;
    @(negedge clk); clr_err[0] = 1'b0;
    m_cnt[0] = 0; m_eaddr[0] = '0; m_seen[0] = 0;
    checks++; if (err_cnt[0] !== 16'd0 || err_addr[0] !== 8'h00) begin errors++; $display("FAIL clr_idle got cnt=%0d addr=%h want 0 00", err_cnt[0], err_addr[0]); end
  endtask

  task automatic test_random();
    int d, vd, rl, lat, rrl; bit vr, rvd, fi;
    logic [7:0] a; logic [3:0] b; logic [31:0] dt, hd, wd;
    for (int n = 0; n < 80; n++) begin
      d = $urandom_range(0, 1);
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        read_op(d, a, lat, dt, rrl, rvd, hd);
        checks++; if (dt !== mdl[d][a] || lat !== lat_of(d)) begin errors++; $display("FAIL rnd_read d=%0d a=%h got %h lat %0d want %h lat %0d", d, a, dt, lat, mdl[d][a], lat_of(d)); end
      end else begin
        b = 4'($urandom_range(0, 15));
        fi = ($urandom_range(0, 3) == 0);
        wd = $urandom;
        write_op(d, a, wd, b, fi, 0, 0, vd, vr, rl);
        checks++; if (vd !== lat_of(d) + 2 || vr !== m_mis[d]) begin errors++; $display("FAIL rnd_verify d=%0d a=%h got vdone@%0d verr=%b want vdone@%0d verr=%b", d, a, vd, vr, lat_of(d) + 2, m_mis[d]); end
        checks++; if (err_cnt[d] !== 16'(m_cnt[d]) || err_addr[d] !== m_eaddr[d]) begin errors++; $display("FAIL rnd_errlog d=%0d got cnt=%0d addr=%h want %0d %h", d, err_cnt[d], err_addr[d], m_cnt[d], m_eaddr[d]); end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; fault_inj[d] = 1'b0; clr_err[d] = 1'b0;
      be[d] = '0; addr[d] = '0; din[d] = '0;
      m_cnt[d] = 0; m_eaddr[d] = '0; m_seen[d] = 0; m_mis[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    preload();
    test_reset();
    test_write_verify();
    test_byte_lanes();
    test_fault();
    test_back_to_back();
    test_reset_vwait();
    test_clr_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
